// File: rtl/nco_clk_gen_pkg.sv
// Shared constants and FSM encoding for the NCO clock-enable generator.
package nco_clk_gen_pkg;

    localparam int unsigned AccWidthDefault = 24;
    localparam int unsigned ChanWDefault    = 3;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StLocked = 2'd2;

    // Settle counter width; a one-cycle settle still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: phase accumulator, live and shadow increments, and a
// carry-aligned increment load so rate changes never produce a runt pulse.
module nco_channel
    import nco_clk_gen_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = AccWidthDefault
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run_i,
    input  logic                 wr_i,
    input  logic [ACC_WIDTH-1:0] wr_inc_i,
    output logic                 pending_o,
    output logic                 tick_o,
    output logic                 clk_out_o
);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] inc_q, inc_d;
    logic [ACC_WIDTH-1:0] shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic                 tick_q, tick_d;
    logic                 clk_out_q, clk_out_d;
    logic [ACC_WIDTH:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    always_comb begin
        acc_d     = acc_q;
        inc_d     = inc_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        tick_d    = 1'b0;
        clk_out_d = clk_out_q;

        if (!run_i) begin
            acc_d     = '0;
            pending_d = 1'b0;
            clk_out_d = 1'b0;
        end else begin
            acc_d     = sum[ACC_WIDTH-1:0];
            tick_d    = sum[ACC_WIDTH];
            clk_out_d = sum[ACC_WIDTH-1];
            // Swap rates exactly at the wrap so the new period starts cleanly.
            if (pending_q && sum[ACC_WIDTH]) begin
                inc_d     = shadow_q;
                pending_d = 1'b0;
            end
        end

        if (wr_i) begin
            shadow_d = wr_inc_i;
            if (!run_i || (inc_q == '0)) begin
                inc_d = wr_inc_i;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            inc_q     <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            inc_q     <= inc_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign pending_o = pending_q;
    assign tick_o    = tick_q;
    assign clk_out_o = clk_out_q;

endmodule

// File: rtl/nco_clk_gen.sv
// Multi-channel fractional clock-enable generator: config decode, settle/lock
// FSM and one nco_channel per output.
module nco_clk_gen
    import nco_clk_gen_pkg::*;
#(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned ACC_WIDTH     = AccWidthDefault,
    parameter int unsigned CHAN_W        = ChanWDefault,
    parameter int unsigned SETTLE_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAN_W-1:0]    cfg_chan,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    output logic [CHANNELS-1:0]  tick,
    output logic [CHANNELS-1:0]  clk_out,
    output logic                 lock
);

    localparam int unsigned     CntW      = cnt_width(SETTLE_CYCLES);
    localparam logic [CntW-1:0] CntLoad   = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CHAN_W:0] ChanLimit = (CHAN_W + 1)'(CHANNELS);

    logic [1:0]          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                lock_q, lock_d;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wr;
    logic                chan_valid;
    logic                cfg_accept;
    logic                run;

    assign run = enable && (state_q != StIdle);

    // Out-of-range channels are always ready and silently dropped.
    always_comb begin
        chan_valid = ({1'b0, cfg_chan} < ChanLimit);
        cfg_ready  = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cfg_chan == CHAN_W'(c)) begin
                cfg_ready = ~pending[c];
            end
        end
        cfg_accept = cfg_valid && cfg_ready;
        wr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr[c] = cfg_accept && (cfg_chan == CHAN_W'(c));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StSettle;
                    cnt_d   = CntLoad;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StLocked;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StLocked: ;
            default: state_d = StIdle;
        endcase

        if ((state_q != StIdle) && cfg_accept && chan_valid) begin
            state_d = StSettle;
            cnt_d   = CntLoad;
        end
        // Dropping enable overrides everything, including a same-cycle write.
        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
        lock_d = (state_d == StLocked);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
        end
    end

    assign lock = lock_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        nco_channel #(
            .ACC_WIDTH(ACC_WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .run_i    (run),
            .wr_i     (wr[c]),
            .wr_inc_i (cfg_inc),
            .pending_o(pending[c]),
            .tick_o   (tick[c]),
            .clk_out_o(clk_out[c])
        );
    end

endmodule
